matrix_generate_3x3_8bit: RTL

MATRIX_GENERATE_3X3_8BIT -- requirements
Module: matrix_generate_3x3_8bit

---
 rtl/matrix_generate_3x3_8bit_pkg.sv | 13 +
 rtl/matrix_generate_3x3_8bit_sync_delay.sv | 34 +++
 rtl/matrix_generate_3x3_8bit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/matrix_generate_3x3_8bit_pkg.sv
// Shared constants for the 3x3 window generator.
package matrix_generate_3x3_8bit_pkg;

    // Default pixel width in bits.
    localparam int DATA_W = 8;

    // Default row/column counter width.
    localparam int CNT_W = 11;

    // Cycles from an input pixel strobe to the matching window output.
    localparam int MATRIX_LATENCY = 2;

endpackage

// File: rtl/matrix_generate_3x3_8bit_sync_delay.sv
// Fixed-depth delay line for the video sync bundle (vsync/href/clken).
// The first stage is exposed separately because the window logic works
// one cycle behind the input, aligned with the line-buffer read data.
module vip_sync_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap1,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift the sync bundle one stage per clock; reset clears every stage
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tap1 = stage_r[0];
    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/matrix_generate_3x3_8bit.sv
// 3x3 neighbourhood generator. Combines the current pixel with two
// line-buffer rows into a sliding window, replicating the first line(s)
// of a frame vertically and the first pixel of a line horizontally.
module matrix_generate_3x3_8bit #(
    parameter int DATA_W = matrix_generate_3x3_8bit_pkg::DATA_W,
    parameter int CNT_W  = matrix_generate_3x3_8bit_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_y,
    input  logic [DATA_W-1:0] row2_data,
    input  logic [DATA_W-1:0] row1_data,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33
);

    import matrix_generate_3x3_8bit_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]        sync_in_s;
    logic [2:0]        sync_d1_s;
    logic [2:0]        sync_out_s;
    logic              vsync_d1, href_d1, clken_d1;
    logic              vsync_d2, href_d2;
    logic              vsync_rise_s, href_fall_s;
    logic [DATA_W-1:0] row3_d;
    logic [CNT_W-1:0]  col_cnt_r;
    logic [CNT_W-1:0]  row_cnt_r;
    logic [DATA_W-1:0] new_top_s, new_mid_s, new_bot_s;

    assign sync_in_s = {per_frame_vsync, per_frame_href, per_frame_clken};

    vip_sync_delay #(
        .DEPTH (MATRIX_LATENCY),
        .WIDTH (3)
    ) u_sync_delay (
        .clock (clock),
        .reset (reset),
        .din   (sync_in_s),
        .tap1  (sync_d1_s),
        .dout  (sync_out_s)
    );

    assign vsync_d1 = sync_d1_s[2];
    assign href_d1  = sync_d1_s[1];
    assign clken_d1 = sync_d1_s[0];
    assign vsync_d2 = sync_out_s[2];
    assign href_d2  = sync_out_s[1];

    assign matrix_frame_vsync = sync_out_s[2];
    assign matrix_frame_href  = sync_out_s[1];
    assign matrix_frame_clken = sync_out_s[0];

    // Edges are taken on the delayed syncs so they line up with clken_d1
    assign vsync_rise_s = vsync_d1 & ~vsync_d2;
    assign href_fall_s  = ~href_d1 & href_d2;

    // Delay the current pixel one cycle to meet the line-buffer read data
    always_ff @(posedge clock) begin
        if (reset) begin
            row3_d <= '0;
        end else begin
            row3_d <= per_img_y;
        end
    end

    // Column position within the line; zero marks the left border
    always_ff @(posedge clock) begin
        if (reset) begin
            col_cnt_r <= '0;
        end else if (!href_d1) begin
            col_cnt_r <= '0;
        end else if (clken_d1 && (col_cnt_r != CNT_MAX)) begin
            col_cnt_r <= col_cnt_r + CNT_W'(1);
        end else begin
            col_cnt_r <= col_cnt_r;
        end
    end

    // Line index within the frame; selects how many buffered rows are real
    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt_r <= '0;
        end else if (vsync_rise_s) begin
            row_cnt_r <= '0;
        end else if (href_fall_s && (row_cnt_r != CNT_MAX)) begin
            row_cnt_r <= row_cnt_r + CNT_W'(1);
        end else begin
            row_cnt_r <= row_cnt_r;
        end
    end

    // Build the incoming column, replicating downward at the top border
    always_comb begin
        new_top_s = row1_data;
        new_mid_s = row2_data;
        new_bot_s = row3_d;
        if (row_cnt_r == CNT_W'(0)) begin
            new_top_s = row3_d;
            new_mid_s = row3_d;
        end else if (row_cnt_r == CNT_W'(1)) begin
            new_top_s = row2_data;
            new_mid_s = row2_data;
        end else begin
            new_top_s = row1_data;
            new_mid_s = row2_data;
        end
    end

    // Shift the window left by one column per pixel; fill it on the first pixel
    always_ff @(posedge clock) begin
        if (reset) begin
            matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
            matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
            matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
        end else if (clken_d1) begin
            if (col_cnt_r == CNT_W'(0)) begin
                matrix_p11 <= new_top_s; matrix_p12 <= new_top_s; matrix_p13 <= new_top_s;
                matrix_p21 <= new_mid_s; matrix_p22 <= new_mid_s; matrix_p23 <= new_mid_s;
                matrix_p31 <= new_bot_s; matrix_p32 <= new_bot_s; matrix_p33 <= new_bot_s;
            end else begin
                matrix_p11 <= matrix_p12; matrix_p12 <= matrix_p13; matrix_p13 <= new_top_s;
                matrix_p21 <= matrix_p22; matrix_p22 <= matrix_p23; matrix_p23 <= new_mid_s;
                matrix_p31 <= matrix_p32; matrix_p32 <= matrix_p33; matrix_p33 <= new_bot_s;
            end
        end
    end

endmodule
